// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Optional FAST_MULT_EN: single-cycle combinational multiply; divides stay iterative.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              write_hi,
    input  logic              write_lo,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic                start_ok;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_step;
    logic [DATA_W:0]     rem_sh, div_diff;
    logic [2*DATA_W-1:0] div_step;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s;

    assign start_ok = start && (state_q == S_IDLE);

    // Signed ops are op[0]==0; magnitudes are iterated, signs fixed up at the end
    assign a_neg = ~op[0] & operand_a[DATA_W-1];
    assign b_neg = ~op[0] & operand_b[DATA_W-1];
    assign a_abs = a_neg ? (~operand_a + 1'b1) : operand_a;
    assign b_abs = b_neg ? (~operand_b + 1'b1) : operand_b;

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? a_q : {DATA_W{1'b0}})};
    assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring divide: acc = {partial remainder, dividend/quotient bits}
    assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_step = div_diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

`ifdef FAST_MULT_EN
    assign prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
`else
    assign prod = acc_q;
`endif

    assign prod_s = neg_res_q ? (~prod + 1'b1) : prod;
    // Divide by zero leaves |a| as remainder, so only the quotient needs forcing
    assign quo_s  = (b_q == {DATA_W{1'b0}}) ? {DATA_W{1'b1}}
                  : (neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0]);
    assign rem_s  = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef FAST_MULT_EN
                    state_d = op[1] ? S_CALC : S_FIX;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    op_d      = op;
                    a_d       = a_abs;
                    b_d       = b_abs;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg & op[1];
                    cnt_d     = {CNT_W{1'b0}};
                    acc_d     = {{DATA_W{1'b0}}, (op[1] ? a_abs : b_abs)};
                end else begin
                    if (write_hi) hi_d = write_data;
                    if (write_lo) lo_d = write_data;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = op_q[1] ? div_step : mul_step;
            end
            S_FIX: begin
                done_d = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*DATA_W-1:DATA_W];
                    lo_d = prod_s[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 2'b00;
            a_q       <= {DATA_W{1'b0}};
            b_q       <= {DATA_W{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= {2*DATA_W{1'b0}};
            hi_q      <= {DATA_W{1'b0}};
            lo_q      <= {DATA_W{1'b0}};
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
    localparam int DIV_LAT = 33;
`ifdef FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mul_div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .write_hi   (write_hi),
        .write_lo   (write_lo),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one op; optionally asserts write_hi with the start and re-pulses start at E0+5
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit whi, input bit restart,
                          input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        write_hi = whi; write_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0; write_hi = 1'b0;
        op = ~o; operand_a = ~a; operand_b = b + 32'd3;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (restart && lat == 4) begin
                start = 1'b1; op = OP_MULTU; operand_a = 32'd100; operand_b = 32'd100;
            end
            if (restart && lat == 5) start = 1'b0;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int done_cnt;
        rstn = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        @(negedge clk);
        write_hi = 1'b1; write_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        check("mthi", {hi, lo}, {32'h0000_1234, 32'd0});
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b1; write_data = 32'h0000_5678;
        @(posedge clk);
        #1;
        check("mtlo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
        @(negedge clk);
        write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h0000_AAAA;
        @(posedge clk);
        #1;
        write_hi = 1'b0; write_lo = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h0000_AAAA, 32'h0000_AAAA});

        @(negedge clk);
        start = 1'b1; op = OP_MULTU; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("calc_busy", {63'd0, busy}, 64'd1);
        repeat (10) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("arst_no_done", 64'(done_cnt), 64'd0);
        check("arst_hilo_after", {hi, lo}, 64'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, MUL_LAT,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b1, 1'b0, MUL_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, DIV_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, DIV_LAT,
               32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, DIV_LAT,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu_rem", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, DIV_LAT,
               32'd2, 32'd14);
        run_op("restart_ign", OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b1, MUL_LAT,
               32'd0, 32'd42);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, DIV_LAT,
               32'hFFFF_FFF9, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
